// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 raster timing constants shared by the timing
// generator and the ball/paddle renderers, plus the derived line/frame totals
// and sync window positions.
//   Contents: timing localparams, derived totals, in_window() helper.
package vga_pkg;

  localparam int CLKS_PER_PIXEL = 2;

  localparam int ACTIVE_COLS = 640;
  localparam int H_FRONT     = 16;
  localparam int H_SYNC      = 96;
  localparam int H_BACK      = 48;

  localparam int ACTIVE_ROWS = 480;
  localparam int V_FRONT     = 10;
  localparam int V_SYNC      = 2;
  localparam int V_BACK      = 33;

  localparam int H_TOTAL = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;

  // Sync windows are half-open: [start, end).
  localparam int H_SYNC_START = ACTIVE_COLS + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = ACTIVE_ROWS + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // True when lo <= pos < hi.
  function automatic logic in_window(input int pos, input int lo, input int hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: clock-enable divider. Produces a one-clk tick every DIV clocks.
// With DIV=1 the counter stays at 0 and tick is permanently high.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   tick out high on the last clk of each DIV-clk period
module clk_en_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] div_r;

  assign tick = (div_r == W'(DIV - 1));

  // Period counter: wraps to 0 on tick (never leaves 0 when DIV=1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= '0;
    end else if (tick) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator for the pong display path.
// Horizontal/vertical counters advance on the pixel enable; all outputs are
// decoded from the current counter state and registered, so they lag the
// counters by one clk and always change together.
//   clk         in  system clock
//   rst         in  asynchronous active-high reset
//   hsync       out horizontal sync, active-low
//   vsync       out vertical sync, active-low
//   active      out inside the visible area
//   row, col    out visible position, forced to 0 during blanking
//   pix_tick    out last clk of each pixel period
//   frame_start out one-clk pulse on pixel (0,0)
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLKS_PER_PIXEL = vga_pkg::CLKS_PER_PIXEL,
  parameter int ACTIVE_COLS    = vga_pkg::ACTIVE_COLS,
  parameter int H_FRONT        = vga_pkg::H_FRONT,
  parameter int H_SYNC         = vga_pkg::H_SYNC,
  parameter int H_BACK         = vga_pkg::H_BACK,
  parameter int ACTIVE_ROWS    = vga_pkg::ACTIVE_ROWS,
  parameter int V_FRONT        = vga_pkg::V_FRONT,
  parameter int V_SYNC         = vga_pkg::V_SYNC,
  parameter int V_BACK         = vga_pkg::V_BACK
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           hsync,
  output logic                           vsync,
  output logic                           active,
  output logic [$clog2(ACTIVE_ROWS)-1:0] row,
  output logic [$clog2(ACTIVE_COLS)-1:0] col,
  output logic                           pix_tick,
  output logic                           frame_start
);

  localparam int H_TOT    = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT    = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = ACTIVE_COLS + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = ACTIVE_ROWS + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int HW       = $clog2(H_TOT);
  localparam int VW       = $clog2(V_TOT);
  localparam int RW       = $clog2(ACTIVE_ROWS);
  localparam int CW       = $clog2(ACTIVE_COLS);

  logic          tick;
  logic [HW-1:0] h_cnt_r;
  logic [VW-1:0] v_cnt_r;

  logic          hsync_s;
  logic          vsync_s;
  logic          active_s;
  logic [RW-1:0] row_s;
  logic [CW-1:0] col_s;
  logic          frame_start_s;

  clk_en_div #(
    .DIV (CLKS_PER_PIXEL)
  ) u_pix_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Raster position: h advances per pixel, v advances on the last pixel of a line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (tick) begin
      if (h_cnt_r == HW'(H_TOT - 1)) begin
        h_cnt_r <= '0;
        if (v_cnt_r == VW'(V_TOT - 1)) begin
          v_cnt_r <= '0;
        end else begin
          v_cnt_r <= v_cnt_r + VW'(1);
        end
      end else begin
        h_cnt_r <= h_cnt_r + HW'(1);
      end
    end else begin
      h_cnt_r <= h_cnt_r;
      v_cnt_r <= v_cnt_r;
    end
  end

  // Output decode from the current counter state.
  always_comb begin
    active_s      = (int'(h_cnt_r) < ACTIVE_COLS) && (int'(v_cnt_r) < ACTIVE_ROWS);
    hsync_s       = !in_window(int'(h_cnt_r), HS_START, HS_END);
    vsync_s       = !in_window(int'(v_cnt_r), VS_START, VS_END);
    frame_start_s = tick && (h_cnt_r == '0) && (v_cnt_r == '0);
    // Blanking forces position to zero so a stray compare cannot match.
    if (active_s) begin
      row_s = RW'(v_cnt_r);
      col_s = CW'(h_cnt_r);
    end else begin
      row_s = '0;
      col_s = '0;
    end
  end

  // Output register stage; everything lags the counters by exactly one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      row         <= '0;
      col         <= '0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_s;
      vsync       <= vsync_s;
      active      <= active_s;
      row         <= row_s;
      col         <= col_s;
      pix_tick    <= tick;
      frame_start <= frame_start_s;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed bench for vga_timing. Three instances share one clock:
//   d: default 640x480 timing (reset release, line timing)
//   a: CLKS_PER_PIXEL=2, 8x6 visible, 16x12 totals (frame timing, mid-frame reset)
//   b: CLKS_PER_PIXEL=1, default horizontal, 4 visible rows, 7 total (divider bypass)
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic       hs_d, vs_d, act_d, pt_d, fs_d;
  logic [8:0] row_d;
  logic [9:0] col_d;
  logic       hs_a, vs_a, act_a, pt_a, fs_a;
  logic [2:0] row_a;
  logic [2:0] col_a;
  logic       hs_b, vs_b, act_b, pt_b, fs_b;
  logic [1:0] row_b;
  logic [9:0] col_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  vga_timing u_dut_d (
    .clk(clk), .rst(rst_d), .hsync(hs_d), .vsync(vs_d), .active(act_d),
    .row(row_d), .col(col_d), .pix_tick(pt_d), .frame_start(fs_d)
  );

  vga_timing #(
    .CLKS_PER_PIXEL(2), .ACTIVE_COLS(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .ACTIVE_ROWS(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .hsync(hs_a), .vsync(vs_a), .active(act_a),
    .row(row_a), .col(col_a), .pix_tick(pt_a), .frame_start(fs_a)
  );

  vga_timing #(
    .CLKS_PER_PIXEL(1), .ACTIVE_ROWS(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .hsync(hs_b), .vsync(vs_b), .active(act_b),
    .row(row_b), .col(col_b), .pix_tick(pt_b), .frame_start(fs_b)
  );

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int el;
    int t_af, t_hf, t_hr, t_ar, row_ar, col_ar, max_col, blank_bad, vs_low;
    int t_fs2, t_vf, t_vr, col_vf, act_vf, max_row, lp_seen, lp_act, found;
    int zeros, t_bf, t_br;
    logic p_act, p_hs, p_vs, p_pt;
    logic [2:0] p_row, p_col;

    // ---------------- default instance: reset release ----------------
    repeat (5) @(posedge clk);
    #1;
    check("d_rst_hsync", hs_d, 1);
    check("d_rst_vsync", vs_d, 1);
    check("d_rst_active", act_d, 0);
    check("d_rst_rowcol", {row_d, col_d}, 0);
    check("d_rst_pix_tick", pt_d, 0);
    check("d_rst_frame_start", fs_d, 0);
    @(negedge clk);
    rst_d = 1'b0;
    #1;
    check("d_release_hsync", hs_d, 1);
    check("d_release_active", act_d, 0);
    step();
    check("d_e1_active", act_d, 1);
    check("d_e1_row", row_d, 0);
    check("d_e1_col", col_d, 0);
    check("d_e1_frame_start", fs_d, 0);
    check("d_e1_pix_tick", pt_d, 0);
    t0 = cyc;
    step();
    check("d_e2_frame_start", fs_d, 1);
    check("d_e2_pix_tick", pt_d, 1);
    check("d_e2_col", col_d, 0);
    step();
    check("d_e3_col", col_d, 1);
    check("d_e3_frame_start", fs_d, 0);

    // ---------------- default instance: one full line ----------------
    t_af = -1; t_hf = -1; t_hr = -1; t_ar = -1; row_ar = -1; col_ar = -1;
    max_col = 0; blank_bad = 0; vs_low = 0;
    p_act = act_d; p_hs = hs_d;
    for (int k = 0; k < 1700; k++) begin
      step();
      el = cyc - t0;
      if (!act_d && p_act && t_af < 0) t_af = el;
      if (act_d && !p_act && t_ar < 0) begin
        t_ar = el; row_ar = row_d; col_ar = col_d;
      end
      if (!hs_d && p_hs && t_hf < 0) t_hf = el;
      if (hs_d && !p_hs && t_hr < 0) t_hr = el;
      if (int'(col_d) > max_col) max_col = col_d;
      if (!act_d && (row_d != 9'd0 || col_d != 10'd0)) blank_bad++;
      if (!vs_d) vs_low++;
      p_act = act_d; p_hs = hs_d;
    end
    check("d_active_fall_clks", t_af, 1280);
    check("d_hsync_fall_clks", t_hf, 1312);
    check("d_hsync_low_clks", t_hr - t_hf, 192);
    check("d_active_return_clks", t_ar, 1600);
    check("d_next_line_row", row_ar, 1);
    check("d_next_line_col", col_ar, 0);
    check("d_max_col", max_col, 639);
    check("d_blank_rowcol_nonzero", blank_bad, 0);
    check("d_vsync_low_in_line0", vs_low, 0);
    rst_d = 1'b1;

    // ---------------- small instance: frame timing ----------------
    @(negedge clk);
    rst_a = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      step();
      if (fs_a) found = 1;
    end
    check("a_first_frame_start_seen", found, 1);
    t0 = cyc;
    t_fs2 = -1; t_vf = -1; t_vr = -1; col_vf = -1; act_vf = -1;
    max_row = 0; max_col = 0; blank_bad = 0; lp_seen = 0; lp_act = -1;
    p_vs = vs_a; p_act = act_a; p_pt = pt_a; p_row = row_a; p_col = col_a;
    for (int k = 0; k < 800; k++) begin
      step();
      el = cyc - t0;
      if (fs_a && t_fs2 < 0) t_fs2 = el;
      if (!vs_a && p_vs && t_vf < 0) begin
        t_vf = el; col_vf = col_a; act_vf = act_a;
      end
      if (vs_a && !p_vs && t_vr < 0) t_vr = el;
      if (int'(row_a) > max_row) max_row = row_a;
      if (int'(col_a) > max_col) max_col = col_a;
      if (!act_a && (row_a != 3'd0 || col_a != 3'd0)) blank_bad++;
      if (lp_seen == 0 && p_act && p_pt && p_row == 3'd5 && p_col == 3'd7) begin
        lp_seen = 1; lp_act = act_a;
      end
      p_vs = vs_a; p_act = act_a; p_pt = pt_a; p_row = row_a; p_col = col_a;
    end
    check("a_frame_period", t_fs2, 384);
    check("a_vsync_fall_offset", t_vf, 255);
    check("a_vsync_low_clks", t_vr - t_vf, 64);
    check("a_vsync_fall_col", col_vf, 0);
    check("a_vsync_fall_active", act_vf, 0);
    check("a_max_row", max_row, 5);
    check("a_max_col", max_col, 7);
    check("a_blank_rowcol_nonzero", blank_bad, 0);
    check("a_last_pixel_seen", lp_seen, 1);
    check("a_after_last_active", lp_act, 0);

    // ---------------- small instance: asynchronous mid-frame reset ----------------
    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      step();
      if (act_a && row_a == 3'd3 && col_a == 3'd5) found = 1;
    end
    check("a_reached_3_5", found, 1);
    #2;
    rst_a = 1'b1;
    #1;
    check("a_async_active", act_a, 0);
    check("a_async_rowcol", {row_a, col_a}, 0);
    check("a_async_syncs", {hs_a, vs_a}, 3);
    check("a_async_ticks", {pt_a, fs_a}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    step();
    check("a_restart_active", act_a, 1);
    check("a_restart_rowcol", {row_a, col_a}, 0);
    check("a_restart_fs_e1", fs_a, 0);
    step();
    check("a_restart_fs_e2", fs_a, 1);

    // ---------------- bypass instance: CLKS_PER_PIXEL=1 ----------------
    check("b_rst_pix_tick", pt_b, 0);
    @(negedge clk);
    rst_b = 1'b0;
    step();
    check("b_e1_frame_start", fs_b, 1);
    check("b_e1_pix_tick", pt_b, 1);
    check("b_e1_active", act_b, 1);
    t0 = cyc;
    zeros = 0; t_fs2 = -1; t_bf = -1; t_br = -1;
    p_hs = hs_b;
    for (int k = 0; k < 5610; k++) begin
      step();
      el = cyc - t0;
      if (!pt_b) zeros++;
      if (fs_b && t_fs2 < 0) t_fs2 = el;
      if (!hs_b && p_hs && t_bf < 0) t_bf = el;
      if (hs_b && !p_hs && t_br < 0) t_br = el;
      p_hs = hs_b;
    end
    check("b_pix_tick_zeros", zeros, 0);
    check("b_frame_period", t_fs2, 5600);
    check("b_hsync_fall_offset", t_bf, 656);
    check("b_hsync_low_clks", t_br - t_bf, 96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates 640x480@60 raster timing for the pong display path. Divides the system clock down to a pixel-rate enable, keeps horizontal and vertical counters, and drives `hsync`/`vsync` to the connector. Drives `row`/`col`/`active` into the ball and paddle renderers, which evaluate object presence against the current pixel.

## Interface
- `CLKS_PER_PIXEL`, 2: system clocks per pixel (50 MHz to 25 MHz); legal values are 1 and above.
- `ACTIVE_COLS`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `ACTIVE_ROWS`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `hsync`  out  1  horizontal sync, active-low.
- `vsync`  out  1  vertical sync, active-low.
- `active`  out  1  high while the position is inside the visible area.
- `row`  out  $clog2(ACTIVE_ROWS)  visible line index; 0 when `active`=0.
- `col`  out  $clog2(ACTIVE_COLS)  visible pixel index; 0 when `active`=0.
- `pix_tick`  out  1  high on the last clk of each pixel period.
- `frame_start`  out  1  one-clk pulse marking pixel (0,0).

## Operation
- **Totals:** H_TOTAL = ACTIVE_COLS+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL likewise (525).
- **Divider:** `div` counts 0..CLKS_PER_PIXEL-1 and wraps; `tick` = (`div`==CLKS_PER_PIXEL-1). When CLKS_PER_PIXEL=1, `div` is 1 bit wide and held at 0, so `tick` is constant 1.
- **Horizontal counter:** `h_cnt` (width $clog2(H_TOTAL)) advances on `tick` and wraps H_TOTAL-1 to 0.
- **Vertical counter:** `v_cnt` (width $clog2(V_TOTAL)) increments only on `tick` when `h_cnt`==H_TOTAL-1, and wraps V_TOTAL-1 to 0. When both wrap on the same tick, both go to 0.
- **Output decode:** computed from the current (`div`, `h_cnt`, `v_cnt`) and registered on every clk:
  - `active` = `h_cnt`<ACTIVE_COLS and `v_cnt`<ACTIVE_ROWS.
  - `hsync` = 0 iff ACTIVE_COLS+H_FRONT ≤ `h_cnt` < ACTIVE_COLS+H_FRONT+H_SYNC (656..751).
  - `vsync` = 0 iff ACTIVE_ROWS+V_FRONT ≤ `v_cnt` < ACTIVE_ROWS+V_FRONT+V_SYNC (490..491).
  - `col`/`row` = `h_cnt`/`v_cnt` truncated to output width when active, else 0.
  - `pix_tick` = `tick`.
  - `frame_start` = `tick` and `h_cnt`==0 and `v_cnt`==0.
- **Gating:** consumers must gate any `row`/`col`-derived presence with `active`.
- **Reset:** asserting `rst` at any time forces `div`=`h_cnt`=`v_cnt`=0. Outputs go to: `hsync`=1, `vsync`=1, `active`=0, `row`=0, `col`=0, `pix_tick`=0, `frame_start`=0. Deasserting restarts the frame at (0,0) with no partial-frame carryover.

## Timing
- Every output is registered and lags the internal counter state by exactly 1 clk. All outputs change together, so position, sync and `active` are mutually consistent in every cycle.
- First clk edge after `rst` falls: `active`=1, `row`=`col`=0. With CLKS_PER_PIXEL=1, `frame_start`=1 on that same cycle. With CLKS_PER_PIXEL=2, `frame_start`=1 on the 2nd edge.
- Each pixel position is held for CLKS_PER_PIXEL clks. `pix_tick` is high in the last of them.
- `frame_start` period is H_TOTAL·V_TOTAL·CLKS_PER_PIXEL clks (840 000 at defaults).
- `hsync` low for H_SYNC·CLKS_PER_PIXEL clks per line. `vsync` low for V_SYNC·H_TOTAL·CLKS_PER_PIXEL clks per frame.
- `vsync` edges coincide with the `h_cnt`==0 output cycle.

## Structure
- Package `vga_pkg` holds the default timing constants, plus derived `H_TOTAL`/`V_TOTAL` and the sync start/end positions. The renderers import it for ACTIVE_ROWS/ACTIVE_COLS.
- Sub-module `clk_en_div` (parameter DIV; ports `clk`, `rst`, `tick`) implements the pixel-enable divider and is reused by game-tick logic.
- The counters and output decode stay in `vga_timing`.

## Test plan
- **Reset release:** hold `rst` 5 clks, release. At release, outputs read `hsync`=1, `vsync`=1, `active`=0. Next edge: `active`=1, (`row`,`col`)=(0,0). `col`=1 after 2 more clks (default CLKS_PER_PIXEL=2).
- **Line timing:** with CLKS_PER_PIXEL=2, `hsync` falls 1312 clks after `col` 0 and stays low 192 clks. `active` falls at `h_cnt` 640 and returns at the next line with `row`+1.
- **Frame timing:** `frame_start` pulses are exactly 840 000 clks apart. `vsync` is low for 3200 clks, starting at `v_cnt` 490. `row` never exceeds 479 and `col` never exceeds 639.
- **Blanking outputs:** throughout blanking, `row`=`col`=0 and `active`=0. At (639,479) the next pixel shows `active`=0.
- **Mid-frame reset:** assert `rst` asynchronously (between edges) at (`row`,`col`)=(200,300). Outputs take reset values immediately, without waiting for a clk edge. After release, the counters restart at (0,0).
- **Divider bypass:** CLKS_PER_PIXEL=1 gives `pix_tick` constant 1 after reset, a `frame_start` period of 420 000 clks, and an `hsync` low width of 96 clks.
